// File: rtl/bcd_mod60_counter.sv
// -----------------------------------------------------------------------------
// bcd_mod60_counter
//
// Two-digit BCD modulo-MODULO counter (minutes stage of the watch controller).
// Counts on a one-cycle tick while running, emits a one-cycle carry on a
// tick-driven wrap, and supports run/stop/clear control plus a manual adjust
// button that steps the digits while the counter is not running.
//
// Parameters:
//   MODULO        count range 0..MODULO-1 (legal 2..100, default 60)
//
// Ports:
//   clk           system clock, all state on the rising edge
//   reset         asynchronous active-low reset
//   tick          one-cycle count enable
//   start_resume  level, requests counting
//   stop          level, requests pause
//   clear         synchronous clear to 00 and IDLE
//   adjust        debounced button level; rising edge steps +1 when not running
//   ones          BCD ones digit
//   tens          BCD tens digit
//   cout          one-cycle carry after a tick-driven wrap
//   running       high while the FSM is in RUN
//   dbg_state     current FSM state (0 IDLE, 1 RUN, 2 PAUSED)
//
// Control handshake: there is no valid/ready pair here; tick and the adjust
// edge are single-cycle qualifiers sampled on the rising edge, and every
// output is registered so it reflects the result of the previous edge.
// -----------------------------------------------------------------------------
module bcd_mod60_counter #(
  parameter int unsigned MODULO = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       start_resume,
  input  logic       stop,
  input  logic       clear,
  input  logic       adjust,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic       cout,
  output logic       running,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_PAUSED = 2'd2
  } state_t;

  // Digit pattern of the terminal value MODULO-1, fixed at elaboration.
  localparam logic [3:0] MAX_TENS = 4'((MODULO - 1) / 10);
  localparam logic [3:0] MAX_ONES = 4'((MODULO - 1) % 10);

  state_t     state_q, state_d;
  logic [3:0] ones_q, ones_d;
  logic [3:0] tens_q, tens_d;
  logic       cout_q, cout_d;
  logic       running_q, running_d;
  logic       adjust_q, adjust_d;

  logic       adj_pulse;
  logic       count_en;
  logic       adj_en;
  logic       at_max;
  logic [3:0] ones_inc;
  logic [3:0] tens_inc;

  // ---------------------------------------------------------------------------
  // State register (FSM plus datapath flops)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      ones_q    <= 4'd0;
      tens_q    <= 4'd0;
      cout_q    <= 1'b0;
      running_q <= 1'b0;
      adjust_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ones_q    <= ones_d;
      tens_q    <= tens_d;
      cout_q    <= cout_d;
      running_q <= running_d;
      adjust_q  <= adjust_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic: clear > stop > start_resume
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:   if (start_resume && !stop) state_d = S_RUN;
        // RUN is held only while start_resume stays high.
        S_RUN:    if (stop || !start_resume) state_d = S_PAUSED;
        S_PAUSED: if (start_resume && !stop) state_d = S_RUN;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output / datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    adjust_d  = adjust;
    adj_pulse = adjust & ~adjust_q;

    // Counting looks at the registered state, so a tick on the IDLE->RUN
    // edge is ignored.
    count_en  = (state_q == S_RUN) && tick && !stop && !clear;
    adj_en    = (state_q != S_RUN) && adj_pulse && !clear;

    at_max    = (ones_q == MAX_ONES) && (tens_q == MAX_TENS);

    ones_inc  = ones_q + 4'd1;
    tens_inc  = tens_q;
    if (at_max) begin
      ones_inc = 4'd0;
      tens_inc = 4'd0;
    end else if (ones_q == 4'd9) begin
      ones_inc = 4'd0;
      tens_inc = tens_q + 4'd1;
    end

    ones_d = ones_q;
    tens_d = tens_q;
    cout_d = 1'b0;
    if (clear) begin
      ones_d = 4'd0;
      tens_d = 4'd0;
    end else if (count_en || adj_en) begin
      ones_d = ones_inc;
      tens_d = tens_inc;
      // Adjust wraps silently so the hour stage is set independently.
      cout_d = count_en && at_max;
    end

    running_d = (state_d == S_RUN);
  end

  assign ones      = ones_q;
  assign tens      = tens_q;
  assign cout      = cout_q;
  assign running   = running_q;
  assign dbg_state = state_q;

endmodule

// File: doc/bcd_mod60_counter.md
# bcd_mod60_counter

Two-digit BCD modulo-N counter (default mod-60) forming the minutes stage of the watch controller, directly upstream of the hour-digit counter. It advances on a one-cycle `tick` enable and holds two BCD digits for the display. It emits a one-cycle `cout` pulse on wrap, which drives the hour stage's advance input. It also provides run/stop/clear control and a button-driven manual adjust for time setting.

## Interface
- `MODULO`, 60: count range 0..MODULO-1; legal 2..100.
- `clk`  in  1  system clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low; forces all state and outputs to reset values immediately.
- `tick`  in  1  one-cycle count enable (1 Hz strobe or lower-stage carry).
- `start_resume`  in  1  level; requests counting.
- `stop`  in  1  level; requests pause.
- `clear`  in  1  synchronous clear to 00 and IDLE.
- `adjust`  in  1  raw debounced button level; rising edge = +1 while not running.
- `ones`  out  4  BCD ones digit, 0..9.
- `tens`  out  4  BCD tens digit, 0..(MODULO-1)/10.
- `cout`  out  1  one-cycle carry pulse on tick-driven wrap.
- `running`  out  1  high while in RUN.

## Operation
- State is kept as two BCD digits. There is no binary value and no divide/modulo operator.
  - Increment: ones 9->0 with tens+1; otherwise ones+1.
  - At value MODULO-1, the increment goes to tens=0, ones=0.
- FSM states: IDLE (reset state), RUN, PAUSED. Per-edge priority is clear > stop > start_resume.
  - Any state, clear=1: go to IDLE, digits=00, cout=0.
  - IDLE: start_resume=1 and stop=0 -> RUN.
  - RUN: stop=1 -> PAUSED. start_resume=0 -> PAUSED.
  - PAUSED: start_resume=1 and stop=0 -> RUN.
- Counting: on an edge where the registered state is RUN, tick=1, stop=0 and clear=0, the digits increment.
  - If that increment wraps MODULO-1 -> 0, cout is registered high for the following cycle.
- Adjust:
  - `adjust` is registered into `adjust_q` (reset 0). An edge pulse is `adjust & ~adjust_q`.
  - The pulse increments the digits only in IDLE or PAUSED.
  - Adjust wraps MODULO-1 -> 0 without asserting cout, so hours are set independently.
  - The pulse is ignored in RUN and ignored when clear=1.
- `running` = (state == RUN), registered.

## Timing
- Reset values: ones=0, tens=0, cout=0, running=0, state=IDLE, adjust_q=0.
- Reset is asynchronous on assertion. On deassertion, counting starts only after a start_resume edge.
- Digit latency: one clock. Outputs change on the same rising edge that samples tick or the adjust edge.
- cout is high exactly one cycle, the cycle after the wrap edge. It is never high two consecutive cycles, even if tick is held high at MODULO-1.
- Tick held high in RUN increments once per clock. No internal edge detection is applied to tick.
- Simultaneous events:
  - tick and stop in RUN: no increment, go to PAUSED.
  - tick and clear: digits=00, cout=0.
  - tick in the same edge as IDLE->RUN: ignored, because the state sampled was IDLE.
  - adjust edge and start_resume in PAUSED: the increment applies, then RUN from the next edge.
- Reset mid-operation, including during a cout cycle: cout drops immediately and digits go to 00.
- Out-of-range digits cannot occur. Clear is the only way to load a value.

## Test plan
- Reset, then start_resume=1, then 60 tick pulses: digits step 00,01,…,59,00. cout is high exactly one cycle after the 59->00 edge, and running=1 throughout.
- Ones/tens rollover: count from 09 with one tick -> tens=1, ones=0. From 19 -> 20. cout stays 0.
- Pause/adjust: at 58, assert stop with a simultaneous tick -> stays 58, running=0. Three adjust rising edges -> 59, 00, 01, with cout never asserted. start_resume -> RUN, and the next tick gives 02.
- Priority: in RUN at 59, assert tick+clear together -> 00, IDLE, cout=0. Adjust held high for 10 cycles in IDLE -> exactly one increment.
- Async reset: assert reset mid-cycle while cout=1 at value 00 and while at 37. Outputs go to 0 before the next clk edge, and ticks are ignored until start_resume.
- Parameter MODULO=24 (if instantiated): count wraps 23->00 with cout. tens never exceeds 2.
